// File: rtl/cc_cond_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, condition
// function codes and flag bit positions used by the CC register and the ALU.
package cc_cond_pkg;

   localparam logic [3:0] ICODE_IRRMOVQ = 4'd2;
   localparam logic [3:0] ICODE_OPQ     = 4'd6;
   localparam logic [3:0] ICODE_JXX     = 4'd7;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 4'd4;

   localparam logic [3:0] C_ALWAYS = 4'd0;
   localparam logic [3:0] C_LE     = 4'd1;
   localparam logic [3:0] C_L      = 4'd2;
   localparam logic [3:0] C_E      = 4'd3;
   localparam logic [3:0] C_NE     = 4'd4;
   localparam logic [3:0] C_GE     = 4'd5;
   localparam logic [3:0] C_G      = 4'd6;

   // Flag vector layout is {ZF,SF,OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_FROZEN = 1'b1
   } cc_state_e;

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over the stored flags.
module cc_cond_eval
   import cc_cond_pkg::*;
(
   input  logic [3:0] icode_i,
   input  logic [3:0] ifun_i,
   input  logic [2:0] cc_i,
   output logic       cnd_o
);

   logic zf;
   logic xo;
   logic raw;

   assign zf = cc_i[CC_ZF];
   assign xo = cc_i[CC_SF] ^ cc_i[CC_OF];

   always_comb begin
      raw = 1'b0;
      unique case (ifun_i)
         C_ALWAYS: raw = 1'b1;
         C_LE:     raw = xo | zf;
         C_L:      raw = xo;
         C_E:      raw = zf;
         C_NE:     raw = ~zf;
         C_GE:     raw = ~xo;
         C_G:      raw = ~xo & ~zf;
         default:  raw = 1'b0;
      endcase
   end

   // Only branches and conditional moves consume a condition
   assign cnd_o = ((icode_i == ICODE_JXX) || (icode_i == ICODE_IRRMOVQ)) ? raw : 1'b0;

endmodule

// File: rtl/cc_cond.sv
// Condition-code register: captures ALU flags on committed OPq, freezes on the
// first bad status, and evaluates the branch/move condition from stored flags.
module cc_cond
   import cc_cond_pkg::*;
#(
   parameter logic [2:0] CC_RESET = 3'b100,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [2:0]       new_cc,
   input  logic [2:0]       stat_in,
   input  logic             stall,
   output logic [2:0]       cc,
   output logic             cnd,
   output logic             halted,
   output logic [CNT_W-1:0] upd_cnt
);

   cc_state_e        state_q, state_d;
   logic [2:0]       cc_q, cc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         cc_q    <= CC_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cc_q    <= cc_d;
         cnt_q   <= cnt_d;
      end
   end

   // A bad status wins over a flag write even when the icode is OPq
   always_comb begin
      state_d = state_q;
      cc_d    = cc_q;
      cnt_d   = cnt_q;
      if (!stall) begin
         unique case (state_q)
            ST_RUN: begin
               if (stat_in != STAT_AOK) begin
                  state_d = ST_FROZEN;
               end else if (icode == ICODE_OPQ) begin
                  cc_d = new_cc;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_FROZEN: begin
               state_d = ST_FROZEN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   cc_cond_eval u_eval (
      .icode_i (icode),
      .ifun_i  (ifun),
      .cc_i    (cc_q),
      .cnd_o   (cnd)
   );

   assign cc      = cc_q;
   assign halted  = (state_q == ST_FROZEN);
   assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_cc_cond.sv
// Randomized self-checking bench for cc_cond against a behavioural flag model,
// with a second narrow-counter instance to exercise saturation.
module tb_cc_cond;

   logic        clk;
   logic        rst;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [2:0]  new_cc;
   logic [2:0]  stat_in;
   logic        stall;
   logic [2:0]  cc;
   logic        cnd;
   logic        halted;
   logic [15:0] upd_cnt;
   logic [2:0]  ccB;
   logic        cndB;
   logic        haltedB;
   logic [1:0]  updCntB;

   int checks;
   int errors;

   logic [2:0] ccModel;
   bit         frozenModel;
   int         commitCount;

   cc_cond dut (
      .clk     (clk),
      .rst     (rst),
      .icode   (icode),
      .ifun    (ifun),
      .new_cc  (new_cc),
      .stat_in (stat_in),
      .stall   (stall),
      .cc      (cc),
      .cnd     (cnd),
      .halted  (halted),
      .upd_cnt (upd_cnt)
   );

   cc_cond #(.CNT_W(2)) dutSmall (
      .clk     (clk),
      .rst     (rst),
      .icode   (icode),
      .ifun    (ifun),
      .new_cc  (new_cc),
      .stat_in (stat_in),
      .stall   (stall),
      .cc      (ccB),
      .cnd     (cndB),
      .halted  (haltedB),
      .upd_cnt (updCntB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Condition read as signed comparison of the last OPq result against zero
   function automatic logic modelCnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] flags);
      bit isZero;
      bit isLess;
      if (ic != 4'd7 && ic != 4'd2) return 1'b0;
      isZero = flags[2];
      isLess = (flags[1] != flags[0]);
      case (fn)
         4'd0: return 1'b1;
         4'd1: return isLess || isZero;
         4'd2: return isLess;
         4'd3: return isZero;
         4'd4: return !isZero;
         4'd5: return !isLess;
         4'd6: return !isLess && !isZero;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int satCount(input int count, input int maxVal);
      return (count > maxVal) ? maxVal : count;
   endfunction

   task automatic checkState(input string tag);
      checkOutput({tag, ".cc"}, 32'(cc), 32'(ccModel));
      checkOutput({tag, ".halted"}, 32'(halted), 32'(frozenModel));
      checkOutput({tag, ".upd_cnt"}, 32'(upd_cnt), 32'(satCount(commitCount, 65535)));
      checkOutput({tag, ".ccSmall"}, 32'(ccB), 32'(ccModel));
      checkOutput({tag, ".cntSmall"}, 32'(updCntB), 32'(satCount(commitCount, 3)));
   endtask

   // Drives one instruction slot, checks cnd before the edge and state after it
   task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] nc,
                                input logic [2:0] st, input logic stl);
      icode = ic; ifun = fn; new_cc = nc; stat_in = st; stall = stl;
      #1;
      checkOutput("cnd", 32'(cnd), 32'(modelCnd(ic, fn, ccModel)));
      checkOutput("cndSmall", 32'(cndB), 32'(modelCnd(ic, fn, ccModel)));
      @(posedge clk);
      if (!stl && !frozenModel) begin
         if (st != 3'd1) begin
            frozenModel = 1'b1;
         end else if (ic == 4'd6) begin
            ccModel = nc;
            commitCount++;
         end
      end
      #1;
      checkState("step");
   endtask

   // Mid-cycle asynchronous reset pulse, checked before any clock edge
   task automatic applyReset();
      #2;
      rst = 1'b1;
      ccModel = 3'b100; frozenModel = 1'b0; commitCount = 0;
      #1;
      checkState("reset");
      rst = 1'b0;
   endtask

   task automatic checkCnd(input string tag, input logic [3:0] fn, input logic expected);
      icode = 4'd7; ifun = fn; stall = 1'b1; stat_in = 3'd1;
      #1;
      checkOutput(tag, 32'(cnd), 32'(expected));
      #1;
   endtask

   initial begin
      logic [3:0] ic;
      logic [2:0] st;
      checks = 0; errors = 0;
      ccModel = 3'b100; frozenModel = 1'b0; commitCount = 0;
      rst = 1'b1; icode = 4'd7; ifun = 4'd3; new_cc = 3'b000; stat_in = 3'd1; stall = 1'b0;
      #12;
      checkOutput("resetCc", 32'(cc), 32'h4);
      checkOutput("resetHalted", 32'(halted), 32'h0);
      checkOutput("resetCnt", 32'(upd_cnt), 32'h0);
      checkOutput("resetJe", 32'(cnd), 32'h1);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(4'd6, 4'd0, 3'b010, 3'd1, 1'b0);
      checkOutput("opqCc", 32'(cc), 32'h2);
      checkOutput("opqCnt", 32'(upd_cnt), 32'h1);
      checkCnd("jlTaken", 4'd2, 1'b1);
      checkCnd("jgeNot", 4'd5, 1'b0);

      applyStimulus(4'd6, 4'd1, 3'b011, 3'd1, 1'b0);
      checkCnd("ovfL", 4'd2, 1'b0);
      checkCnd("ovfG", 4'd6, 1'b1);
      checkCnd("ovfLe", 4'd1, 1'b0);

      applyStimulus(4'd6, 4'd0, 3'b000, 3'd1, 1'b1);
      checkOutput("stallHold", 32'(cc), 32'h3);
      applyStimulus(4'd6, 4'd0, 3'b000, 3'd1, 1'b0);
      checkOutput("stallRelease", 32'(cc), 32'h0);

      applyStimulus(4'd7, 4'd9, 3'b000, 3'd1, 1'b0);
      applyStimulus(4'd6, 4'd0, 3'b000, 3'd1, 1'b0);

      applyStimulus(4'd6, 4'd0, 3'b111, 3'd3, 1'b1);
      checkOutput("stallBadStat", 32'(halted), 32'h0);
      applyStimulus(4'd6, 4'd0, 3'b111, 3'd3, 1'b0);
      checkOutput("freezeHalted", 32'(halted), 32'h1);
      checkOutput("freezeCc", 32'(cc), 32'h0);
      applyStimulus(4'd6, 4'd0, 3'b101, 3'd1, 1'b0);
      checkOutput("frozenNoUpd", 32'(cc), 32'h0);
      applyStimulus(4'd7, 4'd4, 3'b101, 3'd1, 1'b0);
      applyReset();
      checkOutput("rstHalted", 32'(halted), 32'h0);
      checkOutput("rstCc", 32'(cc), 32'h4);

      for (int i = 0; i < 5; i++) applyStimulus(4'd6, 4'd0, 3'(i), 3'd1, 1'b0);
      checkOutput("satSmall", 32'(updCntB), 32'h3);
      checkOutput("satWide", 32'(upd_cnt), 32'h5);

      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: ic = 4'd6;
            4, 5, 6:    ic = 4'd7;
            7:          ic = 4'd2;
            default:    ic = 4'($urandom);
         endcase
         st = ($urandom_range(0, 14) == 0) ? 3'($urandom) : 3'd1;
         applyStimulus(ic, 4'($urandom_range(0, 15)), 3'($urandom), st, ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 59) == 0) applyReset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
